// File: rtl/radiation_sensor_app_if.sv
// Byte-wide application RX/TX link between the ISO 14443A core and the
// radiation sensor application responder.
interface radiation_sensor_app_if;
    logic       rx_soc;
    logic       rx_eoc;
    logic       rx_error;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_req;
    logic       app_resend_last;

    modport master (
        output rx_soc, rx_eoc, rx_error, rx_data, rx_data_valid, tx_req, app_resend_last,
        input  tx_data, tx_data_valid
    );

    modport slave (
        input  rx_soc, rx_eoc, rx_error, rx_data, rx_data_valid, tx_req, app_resend_last,
        output tx_data, tx_data_valid
    );
endinterface

// File: rtl/radiation_sensor_app.sv
// Radiation sensor PICC application layer: event counter, one-byte command
// parser and response buffer with verbatim resend.
module radiation_sensor_app #(
    parameter logic [7:0] VERSION = 8'h01
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          event_pulse,
    radiation_sensor_app_if.slave         bus
);
    localparam int unsigned CNT_W = 32;
    localparam int unsigned LEN_W = 3;
    localparam int unsigned BUF_N = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_TX   = 2'd2
    } state_e;

    state_e                  state_q;
    logic [7:0]              cmd_q;
    logic [1:0]              rx_cnt_q;
    logic [BUF_N-1:0][7:0]   buf_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        idx_q;
    logic                    has_resp_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [7:0]              tx_data_q;
    logic                    tx_valid_q;

    logic [BUF_N-1:0][7:0]   resp_c;
    logic [LEN_W-1:0]        resp_len_c;
    logic                    clear_c;

    // Response frame built from the captured command and the live count
    always_comb begin
        resp_c     = '0;
        resp_len_c = LEN_W'(2);
        if (rx_cnt_q == 2'd2) begin
            resp_c[0] = 8'hFE;
            resp_c[1] = cmd_q;
        end else begin
            case (cmd_q)
                8'h01: begin
                    resp_c     = {cnt_q[7:0], cnt_q[15:8], cnt_q[23:16], cnt_q[31:24], 8'h01};
                    resp_len_c = LEN_W'(5);
                end
                8'h02: begin
                    resp_c[0]  = 8'h02;
                    resp_len_c = LEN_W'(1);
                end
                8'h03: begin
                    resp_c[0] = 8'h03;
                    resp_c[1] = VERSION;
                end
                default: begin
                    resp_c[0] = 8'hFF;
                    resp_c[1] = cmd_q;
                end
            endcase
        end
    end

    // A clear that coincides with an event leaves that event counted
    always_comb begin
        clear_c = (state_q == ST_RX) && bus.rx_eoc && !bus.rx_error && !bus.rx_soc &&
                  (rx_cnt_q == 2'd1) && (cmd_q == 8'h02);
        cnt_d   = cnt_q;
        if (event_pulse && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (clear_c) begin
            cnt_d = CNT_W'(event_pulse);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            rx_cnt_q   <= '0;
            buf_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            has_resp_q <= 1'b0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_soc) begin
                        state_q  <= ST_RX;
                        rx_cnt_q <= '0;
                    end else if (bus.app_resend_last && has_resp_q) begin
                        state_q    <= ST_TX;
                        idx_q      <= '0;
                        tx_data_q  <= buf_q[0];
                        tx_valid_q <= 1'b1;
                    end
                end
                ST_RX: begin
                    if (bus.rx_soc) begin
                        rx_cnt_q <= '0;
                    end else if (bus.rx_eoc) begin
                        if (bus.rx_error || (rx_cnt_q == 2'd0)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q    <= ST_TX;
                            buf_q      <= resp_c;
                            len_q      <= resp_len_c;
                            has_resp_q <= 1'b1;
                            idx_q      <= '0;
                            tx_data_q  <= resp_c[0];
                            tx_valid_q <= 1'b1;
                        end
                    end else if (bus.rx_data_valid) begin
                        if (rx_cnt_q == 2'd0) begin
                            cmd_q <= bus.rx_data;
                        end
                        if (rx_cnt_q != 2'd2) begin
                            rx_cnt_q <= rx_cnt_q + 2'd1;
                        end
                    end
                end
                ST_TX: begin
                    if (bus.rx_soc) begin
                        state_q    <= ST_RX;
                        rx_cnt_q   <= '0;
                        tx_valid_q <= 1'b0;
                    end else if (bus.tx_req) begin
                        if (idx_q == (len_q - LEN_W'(1))) begin
                            state_q    <= ST_IDLE;
                            idx_q      <= '0;
                            tx_valid_q <= 1'b0;
                        end else begin
                            idx_q     <= idx_q + LEN_W'(1);
                            tx_data_q <= buf_q[idx_q + LEN_W'(1)];
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_valid = tx_valid_q;
endmodule

// File: tb/tb_radiation_sensor_app.sv
// Directed bench for radiation_sensor_app: command responses, counter edge
// cases, resend, abort, stall and asynchronous reset.
module tb_radiation_sensor_app;
    logic clk;
    logic rst_n;
    logic event_pulse;
    int   checks;
    int   errors;

    radiation_sensor_app_if bus ();

    radiation_sensor_app #(.VERSION(8'h01)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .event_pulse (event_pulse),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // All stimulus changes at negedge; frame ends one negedge after rx_eoc
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                              input logic err, input logic ev_eoc, input logic do_soc);
        logic [7:0] bytes [2];
        bytes[0] = b0;
        bytes[1] = b1;
        if (do_soc) begin
            bus.rx_soc = 1'b1;
            @(negedge clk);
            bus.rx_soc = 1'b0;
        end
        for (int i = 0; i < nbytes; i++) begin
            bus.rx_data       = bytes[i];
            bus.rx_data_valid = 1'b1;
            @(negedge clk);
            bus.rx_data_valid = 1'b0;
        end
        bus.rx_eoc   = 1'b1;
        bus.rx_error = err;
        event_pulse  = ev_eoc;
        @(negedge clk);
        bus.rx_eoc   = 1'b0;
        bus.rx_error = 1'b0;
        event_pulse  = 1'b0;
    endtask

    // Consume n bytes; exp holds byte 0 in its top octet
    task automatic read_resp(input string tag, input int n, input logic [39:0] exp);
        logic [39:0] e;
        e = exp;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_v%0d", tag, i), 32'(bus.tx_data_valid), 32'd1);
            check($sformatf("%s_b%0d", tag, i), 32'(bus.tx_data), 32'(e[39:32]));
            e = e << 8;
            bus.tx_req = 1'b1;
            @(negedge clk);
            bus.tx_req = 1'b0;
        end
        check($sformatf("%s_end", tag), 32'(bus.tx_data_valid), 32'd0);
    endtask

    task automatic pulse_events(input int n);
        for (int i = 0; i < n; i++) begin
            event_pulse = 1'b1;
            @(negedge clk);
        end
        event_pulse = 1'b0;
    endtask

    task automatic resend();
        bus.app_resend_last = 1'b1;
        @(negedge clk);
        bus.app_resend_last = 1'b0;
    endtask

    initial begin
        logic [7:0] held_data;
        logic       stable;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        event_pulse = 1'b0;
        bus.rx_soc = 1'b0;
        bus.rx_eoc = 1'b0;
        bus.rx_error = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_data_valid = 1'b0;
        bus.tx_req = 1'b0;
        bus.app_resend_last = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", 32'(bus.tx_data), 32'h00);
        check("rst_valid", 32'(bus.tx_data_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        resend();
        check("resend_empty", 32'(bus.tx_data_valid), 32'd0);

        pulse_events(3);
        send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        read_resp("rc3", 5, 40'h01_00_00_00_03);

        pulse_events(2);
        resend();
        read_resp("resend_old", 5, 40'h01_00_00_00_03);

        send_frame(8'h03, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        read_resp("id", 2, 40'h03_01_00_00_00);
        send_frame(8'h7A, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        read_resp("unk", 2, 40'hFF_7A_00_00_00);
        send_frame(8'h01, 8'h55, 2, 1'b0, 1'b0, 1'b1);
        read_resp("long", 2, 40'hFE_01_00_00_00);
        send_frame(8'h01, 8'h00, 1, 1'b1, 1'b0, 1'b1);
        check("err_frame", 32'(bus.tx_data_valid), 32'd0);
        send_frame(8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        check("empty_frame", 32'(bus.tx_data_valid), 32'd0);
        resend();
        read_resp("resend_kept", 2, 40'hFE_01_00_00_00);

        force dut.cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        pulse_events(4);
        send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        read_resp("sat", 5, 40'h01_FF_FF_FF_FF);
        send_frame(8'h02, 8'h00, 1, 1'b0, 1'b1, 1'b1);
        read_resp("clr", 1, 40'h02_00_00_00_00);
        send_frame(8'h01, 8'h00, 1, 1'b0, 1'b1, 1'b1);
        read_resp("after_clr", 5, 40'h01_00_00_00_01);
        send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        read_resp("snap_excl", 5, 40'h01_00_00_00_02);

        send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            bus.tx_req = 1'b1;
            @(negedge clk);
            bus.tx_req = 1'b0;
        end
        check("abort_pre", 32'(bus.tx_data), 32'h00);
        bus.rx_soc = 1'b1;
        @(negedge clk);
        bus.rx_soc = 1'b0;
        check("abort_drop", 32'(bus.tx_data_valid), 32'd0);
        send_frame(8'h03, 8'h00, 1, 1'b0, 1'b0, 1'b0);
        read_resp("abort_new", 2, 40'h03_01_00_00_00);
        resend();
        read_resp("abort_rs", 2, 40'h03_01_00_00_00);

        send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        held_data = bus.tx_data;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.tx_data !== held_data || bus.tx_data_valid !== 1'b1) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_data", 32'(bus.tx_data), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.tx_data_valid), 32'd0);
        check("arst_data", 32'(bus.tx_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        resend();
        check("resend_after_rst", 32'(bus.tx_data_valid), 32'd0);
        @(negedge clk);
        check("resend_after_rst2", 32'(bus.tx_data_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/radiation_sensor_app.md
# radiation_sensor_app

Application-layer responder for the radiation sensor PICC. Sits between the ISO/IEC 14443A core's byte-wide application RX and TX ports. It counts radiation events and parses one-byte commands received from the PCD. It builds the response frame and feeds it byte-by-byte back into the core, including verbatim replay when the core requests a resend.

## Interface

**Parameters**
- `VERSION`, default 8'h01: firmware/version byte returned by READ_ID.

**Ports**
- `clk` input 1: 13.56 MHz recovered carrier clock; stops during pauses.
- `rst_n` input 1: asynchronous active-low reset.
- `event_pulse` input 1: one-cycle pulse per detected radiation event; already synchronous to `clk`.
- `rx_soc` input 1: one-cycle pulse, start of received frame.
- `rx_eoc` input 1: one-cycle pulse, end of received frame.
- `rx_error` input 1: level; frame had a CRC/parity/framing error, valid with `rx_eoc`.
- `rx_data` input 8: received byte.
- `rx_data_valid` input 1: one-cycle pulse, `rx_data` valid.
- `tx_data` output 8: current response byte.
- `tx_data_valid` output 1: response byte available; held with `tx_data` stable until `tx_req`.
- `tx_req` input 1: one-cycle pulse, core consumed `tx_data` and wants the next byte.
- `app_resend_last` input 1: one-cycle pulse, retransmit the previous response.

## Operation

- **Event counter:** 32-bit and saturating at 32'hFFFF_FFFF. It increments on each `event_pulse`.
- **States:** IDLE, RX, TX.
- **IDLE:**
  - `rx_soc` → RX, and clear the rx byte count.
  - `app_resend_last` while a stored response exists → TX from index 0. The buffer is unchanged and there is no new snapshot.
  - `app_resend_last` with no stored response → ignored.
- **RX:**
  - Each `rx_data_valid` captures the first byte as the command and increments the byte count. The count saturates at 2.
  - `rx_eoc` with `rx_error`=1 → IDLE, no response, stored response kept.
  - `rx_eoc` with count 0 → IDLE, no response.
  - Otherwise, build the response into a 5-byte buffer, set length, and go to TX.
- **Response table** (single-byte frames):
  - 8'h01 READ_COUNT → {01, cnt[31:24], cnt[23:16], cnt[15:8], cnt[7:0]}, len 5. The count is snapshotted in the `rx_eoc` cycle.
  - 8'h02 CLEAR_COUNT → {02}, len 1. The counter is cleared in the `rx_eoc` cycle.
  - 8'h03 READ_ID → {03, VERSION}, len 2.
  - Any other cmd → {FF, cmd}, len 2.
  - Frame with ≥2 bytes → {FE, cmd}, len 2, regardless of cmd.
- **TX:**
  - `tx_data` = buf[idx] and `tx_data_valid`=1.
  - On `tx_req`: idx+1. If idx was len-1, drop `tx_data_valid` and go to IDLE.
  - The buffer and len persist after TX for resend.
- **Abort:** `rx_soc` in TX drops `tx_data_valid` next cycle and enters RX. The stored response is retained for a later resend.
- **Ignored inputs:** `rx_data_valid`/`rx_eoc` outside RX, and `tx_req` outside TX.
- **Simultaneous `event_pulse` and CLEAR_COUNT clear:** the count becomes 1.
- **Simultaneous `event_pulse` and READ_COUNT snapshot:** the snapshot excludes that event; the counter includes it.

## Timing

- **Reset values:**
  - `tx_data`=8'h00, `tx_data_valid`=0, counter=0.
  - State IDLE, no stored response, idx=0.
- **Response latency:** `rx_eoc` at cycle N → `tx_data_valid`=1 with byte 0 at N+1.
- **Next byte:** `tx_req` at cycle M → next byte on `tx_data` at M+1. On the last byte, `tx_data_valid`=0 at M+1.
- **Resend latency:** `app_resend_last` at N → `tx_data_valid`=1 at N+1.
- **Handshake:** `tx_data` never changes while `tx_data_valid`=1 except in the cycle after `tx_req`.
- **Reset mid-frame or mid-TX:** immediate return to reset values. The stored response is lost and a later resend is ignored.
- **Counter arithmetic:** at 32'hFFFF_FFFF, `event_pulse` leaves the value unchanged.
- **Clock stop:** all state simply holds when `clk` stops during pauses.

## Test plan

- 3 `event_pulse`s, then rx {01} with a clean `rx_eoc` → TX 01,00,00,00,03. `tx_valid` rises 1 cycle after `rx_eoc` and falls 1 cycle after the 5th `tx_req`.
- Counter preloaded to 32'hFFFF_FFFE, 4 events, then READ_COUNT → 01,FF,FF,FF,FF. Then CLEAR_COUNT with `event_pulse` in the `rx_eoc` cycle → response 02, and a following READ_COUNT returns 01,00,00,00,01.
- rx {03} → 03,01. rx {7A} → FF,7A. rx {01,55} → FE,01. rx {01} with `rx_error` → no `tx_data_valid`. Zero-byte frame → no response.
- After READ_COUNT, generate 2 events, then pulse `app_resend_last` → identical 5 bytes (old count). Resend after reset → no `tx_data_valid`.
- `rx_soc` after 2 of 5 bytes consumed → `tx_data_valid`=0 next cycle. A new rx {03} → 03,01. Then a resend → 03,01.
- Stall: hold `tx_req` low 50 cycles → `tx_data` and `tx_data_valid` stable. Assert `rst_n` low mid-TX → outputs reset asynchronously.
